pulse_hs_tx: RTL

PULSE_HS_TX -- requirements
Module: pulse_hs_tx

---
 rtl/pulse_hs_pkg.sv | 15 +
 rtl/sync_nff.sv | 24 ++
 rtl/pulse_hs_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pulse_hs_pkg.sv
// Shared types and default constants for the pulse_hs_tx block.
// Optional macro: PULSE_HS_TX_TIMEOUT_EN (phase timeout abort).
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } hs_state_t;

  localparam int SYNC_STAGES_D = 2;
  localparam int PEND_W_D      = 4;
  localparam int TIMEOUT_CYC_D = 1024;

endpackage

// File: rtl/sync_nff.sv
// Parameterized-depth level synchronizer.
// Async active-low reset clears every stage.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Pulse-to-4-phase handshake transmitter with pending-event queue.
// Optional macro: PULSE_HS_TX_TIMEOUT_EN adds o_timeout and phase abort.
module pulse_hs_tx
  import pulse_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int PEND_W      = PEND_W_D,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pulse,
  input  logic              i_ack,
  output logic              o_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [PEND_W-1:0] o_pend_cnt,
  output logic              o_overflow
`ifdef PULSE_HS_TX_TIMEOUT_EN
  ,
  output logic              o_timeout
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("pulse_hs_tx: bad parameters");
  end

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  hs_state_t state;
  logic      ack_s;
  logic      launch;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (i_ack),
    .q    (ack_s)
  );

  // Never start a new phase while the far end still shows ack.
  assign launch = (state == IDLE) && !ack_s &&
                  (i_pulse || (o_pend_cnt != '0));

`ifdef PULSE_HS_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  logic          aborted;
  logic          to_hit;
  assign to_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      o_req  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef PULSE_HS_TX_TIMEOUT_EN
      tcnt      <= '0;
      aborted   <= 1'b0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef PULSE_HS_TX_TIMEOUT_EN
      o_timeout <= 1'b0;
      tcnt <= (state == IDLE) ? '0 : tcnt + TW'(1);
`endif
      unique case (state)
        IDLE: begin
          if (launch) begin
            state  <= REQ_HI;
            o_req  <= 1'b1;
            o_busy <= 1'b1;
`ifdef PULSE_HS_TX_TIMEOUT_EN
            aborted <= 1'b0;
`endif
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            state <= ACK_LO;
            o_req <= 1'b0;
`ifdef PULSE_HS_TX_TIMEOUT_EN
            tcnt  <= '0;
          end else if (to_hit) begin
            state     <= ACK_LO;
            o_req     <= 1'b0;
            tcnt      <= '0;
            aborted   <= 1'b1;
            o_timeout <= 1'b1;
`endif
          end
        end
        ACK_LO: begin
          if (!ack_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
`ifdef PULSE_HS_TX_TIMEOUT_EN
            o_done <= !aborted;
            tcnt   <= '0;
          end else if (to_hit) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            tcnt      <= '0;
            o_timeout <= 1'b1;
`else
            o_done <= 1'b1;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          o_req  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // A launch with a coincident pulse nets to zero change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pend_cnt <= '0;
      o_overflow <= 1'b0;
    end else if (launch) begin
      if ((o_pend_cnt != '0) && !i_pulse) begin
        o_pend_cnt <= o_pend_cnt - 1'b1;
      end
    end else if (i_pulse) begin
      if (o_pend_cnt == PEND_MAX) begin
        o_overflow <= 1'b1;
      end else begin
        o_pend_cnt <= o_pend_cnt + 1'b1;
      end
    end
  end

endmodule
